// File: rtl/alu_core_mc.sv
// Multi-cycle integer ALU: single-cycle arithmetic/logic ops, bit-serial shifts, persistent flags.
// Optional overflow flag (and flagSwitch=7 branch on it) enabled by defining ALU_OVERFLOW_FLAG_EN.
module alu_core_mc #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       opSwitch,
  input  logic [2:0]       flagSwitch,
  input  logic             isLog,
  input  logic             dir,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             sign_flag,
`ifdef ALU_OVERFLOW_FLAG_EN
  output logic             overflow_flag,
`endif
  output logic             branch_taken
);

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_COMP  = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_XOR   = 3'd3;
  localparam logic [2:0] OP_SHIFT = 3'd4;
  localparam logic [2:0] OP_SUB   = 3'd5;
  localparam logic [2:0] OP_PASSB = 3'd6;
  localparam logic [2:0] OP_PASSA = 3'd7;

  localparam logic [2:0] FS_ZERO   = 3'd1;
  localparam logic [2:0] FS_NZERO  = 3'd2;
  localparam logic [2:0] FS_CARRY  = 3'd3;
  localparam logic [2:0] FS_NCARRY = 3'd4;
  localparam logic [2:0] FS_SIGN   = 3'd5;
  localparam logic [2:0] FS_ALWAYS = 3'd6;
  localparam logic [2:0] FS_OVF    = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               sign_q, sign_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               shift_log_q, shift_log_d;
  logic               shift_right_q, shift_right_d;
`ifdef ALU_OVERFLOW_FLAG_EN
  logic               ovf_q, ovf_d;
  logic               add_ovf, sub_ovf;
`endif

  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     diff_ext;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   shift_next;
  logic               shift_out;
  logic               shift_fill;
  logic [WIDTH-1:0]   op_res;
  logic               latch_en;
  logic               branch_c;

  // SUB is a + ~b + 1 at WIDTH+1 bits, so the top bit is the no-borrow carry.
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign shamt    = b[SHAMT_W-1:0];

`ifdef ALU_OVERFLOW_FLAG_EN
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
`endif

  always_comb begin
    shift_fill = shift_log_q ? 1'b0 : shreg_q[WIDTH-1];
    shift_out  = shift_right_q ? shreg_q[0] : shreg_q[WIDTH-1];
    shift_next = shift_right_q ? {shift_fill, shreg_q[WIDTH-1:1]}
                               : {shreg_q[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    state_d       = state_q;
    result_d      = result_q;
    carry_d       = carry_q;
    zero_d        = zero_q;
    sign_d        = sign_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    shift_log_d   = shift_log_q;
    shift_right_d = shift_right_q;
`ifdef ALU_OVERFLOW_FLAG_EN
    ovf_d         = ovf_q;
`endif
    op_res        = '0;
    latch_en      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_DONE;
          latch_en = 1'b1;
          case (opSwitch)
            OP_ADD: begin
              op_res  = sum_ext[WIDTH-1:0];
              carry_d = sum_ext[WIDTH];
`ifdef ALU_OVERFLOW_FLAG_EN
              ovf_d   = add_ovf;
`endif
            end
            OP_COMP:  op_res = ~b + {{(WIDTH-1){1'b0}}, 1'b1};
            OP_AND:   op_res = a & b;
            OP_XOR:   op_res = a ^ b;
            OP_SHIFT: begin
              // A zero shift amount completes immediately with carry untouched.
              op_res = a;
              if (shamt != '0) begin
                state_d       = ST_SHIFT;
                latch_en      = 1'b0;
                shreg_d       = a;
                cnt_d         = shamt;
                shift_log_d   = isLog;
                shift_right_d = dir;
              end
            end
            OP_SUB: begin
              op_res  = diff_ext[WIDTH-1:0];
              carry_d = diff_ext[WIDTH];
`ifdef ALU_OVERFLOW_FLAG_EN
              ovf_d   = sub_ovf;
`endif
            end
            OP_PASSB: op_res = b;
            OP_PASSA: op_res = a;
            default:  op_res = '0;
          endcase
        end
      end
      ST_SHIFT: begin
        shreg_d = shift_next;
        cnt_d   = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d  = ST_DONE;
          latch_en = 1'b1;
          op_res   = shift_next;
          carry_d  = shift_out;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (latch_en) begin
      result_d = op_res;
      zero_d   = (op_res == '0);
      sign_d   = op_res[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      result_q      <= '0;
      carry_q       <= 1'b0;
      zero_q        <= 1'b0;
      sign_q        <= 1'b0;
      shreg_q       <= '0;
      cnt_q         <= '0;
      shift_log_q   <= 1'b0;
      shift_right_q <= 1'b0;
`ifdef ALU_OVERFLOW_FLAG_EN
      ovf_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      result_q      <= result_d;
      carry_q       <= carry_d;
      zero_q        <= zero_d;
      sign_q        <= sign_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      shift_log_q   <= shift_log_d;
      shift_right_q <= shift_right_d;
`ifdef ALU_OVERFLOW_FLAG_EN
      ovf_q         <= ovf_d;
`endif
    end
  end

  // Branch decision looks only at the registered flags, never at an op in flight.
  always_comb begin
    branch_c = 1'b0;
    case (flagSwitch)
      FS_ZERO:   branch_c = zero_q;
      FS_NZERO:  branch_c = ~zero_q;
      FS_CARRY:  branch_c = carry_q;
      FS_NCARRY: branch_c = ~carry_q;
      FS_SIGN:   branch_c = sign_q;
      FS_ALWAYS: branch_c = 1'b1;
`ifdef ALU_OVERFLOW_FLAG_EN
      FS_OVF:    branch_c = ovf_q;
`else
      FS_OVF:    branch_c = 1'b0;
`endif
      default:   branch_c = 1'b0;
    endcase
  end

  assign result       = result_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign carry_flag   = carry_q;
  assign zero_flag    = zero_q;
  assign sign_flag    = sign_q;
  assign branch_taken = branch_c;
`ifdef ALU_OVERFLOW_FLAG_EN
  assign overflow_flag = ovf_q;
`endif

endmodule

// File: tb/tb_alu_core_mc.sv
// Self-checking bench for alu_core_mc: event-scheduled reference model plus directed literal cases.
module tb_alu_core_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  opSwitch;
  logic [2:0]  flagSwitch;
  logic        isLog;
  logic        dir;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic        busy;
  logic        done;
  logic        carry_flag;
  logic        zero_flag;
  logic        sign_flag;
  logic        branch_taken;
`ifdef ALU_OVERFLOW_FLAG_EN
  logic        overflow_flag;
`endif

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  alu_core_mc #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .opSwitch     (opSwitch),
    .flagSwitch   (flagSwitch),
    .isLog        (isLog),
    .dir          (dir),
    .a            (a),
    .b            (b),
    .result       (result),
    .busy         (busy),
    .done         (done),
    .carry_flag   (carry_flag),
    .zero_flag    (zero_flag),
    .sign_flag    (sign_flag),
`ifdef ALU_OVERFLOW_FLAG_EN
    .overflow_flag(overflow_flag),
`endif
    .branch_taken (branch_taken)
  );

  always #5 clk = ~clk;

  // Reference model: each accepted request is scheduled to complete at a known edge.
  int          cyc         = 0;
  bit          m_inflight  = 1'b0;
  int          m_commit    = 0;
  bit          m_done      = 1'b0;
  logic [31:0] m_result    = '0;
  bit          m_carry     = 1'b0;
  bit          m_zero      = 1'b0;
  bit          m_sign      = 1'b0;
  bit          m_ovf       = 1'b0;
  logic [31:0] p_result    = '0;
  bit          p_carry_upd = 1'b0;
  bit          p_carry     = 1'b0;
  bit          p_ovf_upd   = 1'b0;
  bit          p_ovf       = 1'b0;

  function automatic int computeOp(logic [2:0] op, logic il, logic dr,
                                   logic [31:0] x, logic [31:0] y);
    longint sx, sy, s;
    int n;
    int lat = 0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p_carry_upd = 1'b0;
    p_ovf_upd   = 1'b0;
    case (op)
      3'd0: begin
        p_result    = x + y;
        p_carry     = ({1'b0, x} + {1'b0, y}) > 33'h0FFFFFFFF;
        p_carry_upd = 1'b1;
        s           = sx + sy;
        p_ovf       = (s > 2147483647) || (s < -longint'(2147483647) - 1);
        p_ovf_upd   = 1'b1;
      end
      3'd1: p_result = 32'd0 - y;
      3'd2: p_result = x & y;
      3'd3: p_result = x ^ y;
      3'd4: begin
        n = int'(y[4:0]);
        p_result = x;
        if (n != 0) begin
          lat         = n;
          p_carry_upd = 1'b1;
          if (!dr) begin
            p_result = x << n;
            p_carry  = x[32-n];
          end else if (il) begin
            p_result = x >> n;
            p_carry  = x[n-1];
          end else begin
            p_result = $signed(x) >>> n;
            p_carry  = x[n-1];
          end
        end
      end
      3'd5: begin
        p_result    = x - y;
        p_carry     = (x >= y);
        p_carry_upd = 1'b1;
        s           = sx - sy;
        p_ovf       = (s > 2147483647) || (s < -longint'(2147483647) - 1);
        p_ovf_upd   = 1'b1;
      end
      3'd6: p_result = y;
      default: p_result = x;
    endcase
    return lat;
  endfunction

  function automatic void commitOp();
    m_result = p_result;
    m_zero   = (p_result == 32'd0);
    m_sign   = p_result[31];
    if (p_carry_upd) m_carry = p_carry;
    if (p_ovf_upd)   m_ovf   = p_ovf;
    m_done = 1'b1;
  endfunction

  function automatic bit expBranch(logic [2:0] fs);
    case (fs)
      3'd1: return m_zero;
      3'd2: return !m_zero;
      3'd3: return m_carry;
      3'd4: return !m_carry;
      3'd5: return m_sign;
      3'd6: return 1'b1;
`ifdef ALU_OVERFLOW_FLAG_EN
      3'd7: return m_ovf;
`endif
      default: return 1'b0;
    endcase
  endfunction

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_inflight = 1'b0;
      m_done     = 1'b0;
      m_result   = '0;
      m_carry    = 1'b0;
      m_zero     = 1'b0;
      m_sign     = 1'b0;
      m_ovf      = 1'b0;
    end else begin
      cyc++;
      m_done = 1'b0;
      if (!m_inflight) begin
        if (start) begin
          m_inflight = 1'b1;
          m_commit   = cyc + computeOp(opSwitch, isLog, dir, a, b);
          if (m_commit == cyc) commitOp();
        end
      end else if (cyc == m_commit) begin
        commitOp();
      end else if (cyc == m_commit + 1) begin
        m_inflight = 1'b0;
      end
    end
  end

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic checkBit(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (cmp_en && !reset) begin
      checkBit("cyc_busy", busy, m_inflight);
      checkBit("cyc_done", done, m_done);
      checkOutput("cyc_result", result, m_result);
      checkBit("cyc_carry", carry_flag, m_carry);
      checkBit("cyc_zero", zero_flag, m_zero);
      checkBit("cyc_sign", sign_flag, m_sign);
      checkBit("cyc_branch", branch_taken, expBranch(flagSwitch));
`ifdef ALU_OVERFLOW_FLAG_EN
      checkBit("cyc_ovf", overflow_flag, m_ovf);
`endif
    end
  end

  task automatic applyStimulus(logic [2:0] op, logic [2:0] fs, logic il, logic dr,
                               logic [31:0] av, logic [31:0] bv);
    opSwitch   = op;
    flagSwitch = fs;
    isLog      = il;
    dir        = dr;
    a          = av;
    b          = bv;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pickWord();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    int dcount;
    int dk;
    reset = 1'b0; start = 1'b0; opSwitch = '0; flagSwitch = '0;
    isLog = 1'b0; dir = 1'b0; a = '0; b = '0;
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cmp_en = 1'b1;

    checkOutput("rst_result", result, 32'h0);
    checkBit("rst_busy", busy, 1'b0);
    checkBit("rst_done", done, 1'b0);
    checkBit("rst_flags", carry_flag | zero_flag | sign_flag, 1'b0);

    applyStimulus(3'd0, 3'd1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1);
    waitDone(lat);
    checkOutput("add_latency", lat, 0);
    checkOutput("add_result", result, 32'h0);
    checkBit("add_carry", carry_flag, 1'b1);
    checkBit("add_zero", zero_flag, 1'b1);
    checkBit("add_sign", sign_flag, 1'b0);
    checkBit("add_branch_zero", branch_taken, 1'b1);
    idleCycle();

    applyStimulus(3'd4, 3'd5, 1'b0, 1'b1, 32'h8000_0000, 32'd4);
    checkBit("sra_busy", busy, 1'b1);
    waitDone(lat);
    checkOutput("sra_latency", lat, 4);
    checkOutput("sra_result", result, 32'hF800_0000);
    checkBit("sra_sign", sign_flag, 1'b1);
    checkBit("sra_carry", carry_flag, 1'b0);
    idleCycle();

    applyStimulus(3'd4, 3'd3, 1'b0, 1'b0, 32'h4000_0001, 32'd2);
    waitDone(lat);
    checkOutput("shl_latency", lat, 2);
    checkOutput("shl_result", result, 32'h0000_0004);
    checkBit("shl_carry", carry_flag, 1'b1);
    idleCycle();

    applyStimulus(3'd4, 3'd3, 1'b1, 1'b0, 32'h1234_5678, 32'd0);
    waitDone(lat);
    checkOutput("sh0_latency", lat, 0);
    checkOutput("sh0_result", result, 32'h1234_5678);
    checkBit("sh0_carry_kept", carry_flag, 1'b1);
    idleCycle();

    applyStimulus(3'd5, 3'd4, 1'b0, 1'b0, 32'd3, 32'd5);
    waitDone(lat);
    checkOutput("sub_latency", lat, 0);
    checkOutput("sub_result", result, 32'hFFFF_FFFE);
    checkOutput("model_sub_result", m_result, 32'hFFFF_FFFE);
    checkBit("sub_carry", carry_flag, 1'b0);
    checkBit("sub_sign", sign_flag, 1'b1);
    checkBit("sub_branch_ncarry", branch_taken, 1'b1);
    checkBit("model_sub_ovf", m_ovf, 1'b0);
`ifdef ALU_OVERFLOW_FLAG_EN
    checkBit("sub_ovf", overflow_flag, 1'b0);
`endif
    idleCycle();

    // Second request while a shift is in flight must be dropped.
    applyStimulus(3'd4, 3'd0, 1'b1, 1'b0, 32'h0000_00FF, 32'd8);
    dcount = 0;
    dk = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) begin
        opSwitch = 3'd0; a = 32'd1; b = 32'd2; start = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done === 1'b1) begin
        dcount++;
        if (dk == 0) dk = k;
        checkOutput("busy_start_result", result, 32'h0000_FF00);
      end
    end
    checkOutput("busy_start_done_count", dcount, 1);
    checkOutput("busy_start_done_cycle", dk, 8);

    // Reset in the middle of a long shift aborts it without a done pulse.
    applyStimulus(3'd4, 3'd0, 1'b1, 1'b0, 32'h1, 32'd31);
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #10 reset = 1'b0;
    checkOutput("midrst_result", result, 32'h0);
    checkBit("midrst_busy", busy, 1'b0);
    checkBit("midrst_flags", carry_flag | zero_flag | sign_flag, 1'b0);
    dcount = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dcount++;
    end
    checkOutput("midrst_no_done", dcount, 0);

    for (int i = 0; i < 3000; i++) begin
      start      = ($urandom_range(0, 2) == 0);
      opSwitch   = 3'($urandom_range(0, 7));
      flagSwitch = 3'($urandom_range(0, 7));
      isLog      = 1'($urandom_range(0, 1));
      dir        = 1'($urandom_range(0, 1));
      a          = pickWord();
      b          = ($urandom_range(0, 1) == 1) ? pickWord() : 32'($urandom_range(0, 31));
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
